regfile_req_ctrl: RTL and testbench
===================================

// Module: regfile_req_ctrl
// PURPOSE
//  Initiator side of the register-file port: drives raddr/ren and waddr/wen/wdata of regfile_swc.
//  Takes decoded operand requests, tracks in-flight destinations in a scoreboard and stalls on RAW hazards.
//  Issues reads, latches the registered read data and hands operands to execute via valid/ready.
//  Also accepts writebacks and registers them onto the regfile write port. Sits between decode and exu.
// PARAMETERS
//  XLEN   32  data width
//  AW     5   register address width (2**AW registers)
// PORTS
//  hclk         in   1     clock
//  hrstn        in   1     reset, asynchronous, active-low
//  id_valid     in   1     decode request valid
//  id_ready     out  1     request accepted when id_valid&&id_ready
//  id_rs1/rs2   in   AW    source addresses
//  id_use_rs1/2 in   1     source is used
//  id_rd        in   AW    destination address
//  id_rd_wen    in   1     instruction writes rd
//  op_valid     out  1     operands valid to execute
//  op_ready     in   1     execute accepts operands
//  op_rs1/2_data out XLEN  operand data (0 if source unused)
//  op_rd        out  AW    captured rd
//  op_rd_wen    out  1     captured rd_wen
//  wb_valid     in   1     writeback request
//  wb_ready     out  1     constant 1
//  wb_rd        in   AW    writeback address
//  wb_data      in   XLEN  writeback data
//  reg_raddr_1/2 out AW    regfile read addresses
//  reg_ren_1/2  out  1     regfile read enables
//  reg_rdata_1/2 in  XLEN  regfile read data (1-cycle registered, 0 when ren low)
//  reg_waddr    out  AW    regfile write address
//  reg_wen      out  1     regfile write enable
//  reg_wdata    out  XLEN  regfile write data
//  busy_mask    out  2**AW scoreboard, bit n = rd n has a producer in flight
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, except wb_ready=1 (const) and id_ready=1 (IDLE); busy_mask=0.
//  FSM IDLE -> (STALL|ISSUE) -> CAPTURE -> VALID -> IDLE. id_ready=1 only in IDLE.
//  Hazard = (use_rs1 && rs1!=0 && busy[rs1]) || (use_rs2 && rs2!=0 && busy[rs2]), on captured fields;
//   a busy bit being cleared by a wb fire in the same cycle counts as not busy.
//  IDLE: on accept capture rs1/rs2/rd/uses/rd_wen; hazard(on incoming fields) ? STALL : ISSUE.
//  STALL: re-evaluate every cycle; when clear -> ISSUE.
//  ISSUE (1 cycle): reg_ren_x=use_rs_x, reg_raddr_x=rs_x; -> CAPTURE. raddr holds value outside ISSUE.
//  CAPTURE (1 cycle): latch reg_rdata_1/2 into op_rs1/2_data; -> VALID.
//  VALID: op_valid=1, data/rd stable until op_valid&&op_ready; then -> IDLE, op_valid=0 next cycle.
//  Latency: accept edge to op_valid = 3 cycles with no hazard; op_valid held indefinitely under backpressure.
//  Writeback: wb_ready=1; on wb_valid, next cycle reg_wen=(wb_rd!=0), reg_waddr=wb_rd, reg_wdata=wb_data,
//   reg_wen high exactly 1 cycle per wb. Read in same cycle as that write relies on regfile bypass.
//  Scoreboard: op fire with op_rd_wen&&op_rd!=0 sets busy[op_rd]; wb fire clears busy[wb_rd];
//   same index set+clear in one cycle -> set wins. busy[0] always 0. wb to non-busy rd: write still issued.
//  Back-to-back wb every cycle supported; wb independent of FSM state.
//  Reset mid-operation: in-flight request dropped, busy_mask cleared, pending reg_wen cancelled.
// TESTING
//  No hazard: rs1=3,rs2=4 (rf 0x11,0x22) -> ren_1/2 high 1 cycle after accept, op_valid at +3, data 0x11/0x22.
//  RAW stall: op fires rd=5 wen; next req rs1=5 -> STALL, busy[5]=1; wb rd=5 data 0xABCD -> op_rs1_data=0xABCD, busy[5]=0.
//  Backpressure: op_ready=0 for 10 cycles -> op_valid and data stable, id_ready=0; release -> IDLE next cycle.
//  rd0/unused: rs1=0 used, rs2 unused -> no stall, ren_2=0, op data 0/0; wb rd=0 -> reg_wen stays 0.
//  Set/clear collision: op fire rd=7 and wb rd=7 same cycle -> busy[7]=1 after edge.
//  Reset in STALL and during pending wb -> all outputs 0, busy_mask=0, reg_wen not asserted.

Source files
------------

// File: rtl/regfile_req_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_req_ctrl
//
// Initiator side of the register-file port, sitting between decode and
// execute. It accepts one decoded operand request at a time, stalls while a
// used source register still has a producer in flight, reads the operands
// through the regfile read ports, and presents them to execute. It also
// forwards writebacks onto the regfile write port and keeps a scoreboard of
// destinations that have been handed to execute but not yet written back.
//
// Handshakes: a transfer happens on a rising hclk edge where valid && ready
// are both high. A valid, once raised, holds together with its payload until
// that transfer; ready may change freely and does not depend on valid.
//
// Ports
//   hclk, hrstn                       clock, asynchronous active-low reset
//   id_valid / id_ready               decode request handshake (ready only in IDLE)
//   id_rs1, id_rs2, id_use_rs1/2      source addresses and use flags
//   id_rd, id_rd_wen                  destination address and write flag
//   op_valid / op_ready               operand handshake towards execute
//   op_rs1_data, op_rs2_data          operand data (0 when the source is unused)
//   op_rd, op_rd_wen                  captured destination fields
//   wb_valid / wb_ready               writeback handshake (ready always 1)
//   wb_rd, wb_data                    writeback address and data
//   reg_raddr_1/2, reg_ren_1/2        regfile read request (data 1 cycle later)
//   reg_rdata_1/2                     regfile read data
//   reg_waddr, reg_wen, reg_wdata     regfile write port
//   busy_mask                         scoreboard, bit n = rd n in flight
//   dbg_state                         current FSM state
// ---------------------------------------------------------------------------
module regfile_req_ctrl #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 hclk,
    input  logic                 hrstn,
    // decode request
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [AW-1:0]        id_rs1,
    input  logic [AW-1:0]        id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_rd_wen,
    // operands to execute
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [XLEN-1:0]      op_rs1_data,
    output logic [XLEN-1:0]      op_rs2_data,
    output logic [AW-1:0]        op_rd,
    output logic                 op_rd_wen,
    // writeback
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [AW-1:0]        wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    // regfile port
    output logic [AW-1:0]        reg_raddr_1,
    output logic [AW-1:0]        reg_raddr_2,
    output logic                 reg_ren_1,
    output logic                 reg_ren_2,
    input  logic [XLEN-1:0]      reg_rdata_1,
    input  logic [XLEN-1:0]      reg_rdata_2,
    output logic [AW-1:0]        reg_waddr,
    output logic                 reg_wen,
    output logic [XLEN-1:0]      reg_wdata,
    // status
    output logic [(1<<AW)-1:0]   busy_mask,
    output logic [2:0]           dbg_state
);

    localparam int NREG = 1 << AW;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_STALL   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_VALID   = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;

    // captured request
    logic [AW-1:0]    r_rs1;
    logic [AW-1:0]    r_rs2;
    logic             r_use1;
    logic             r_use2;
    logic [AW-1:0]    r_rd;
    logic             r_rd_wen;

    logic [AW-1:0]    r_raddr_1;
    logic [AW-1:0]    r_raddr_2;
    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;

    logic [NREG-1:0]  r_busy;
    logic [NREG-1:0]  w_busy_nxt;
    logic [NREG-1:0]  w_wb_clr;
    logic [NREG-1:0]  w_op_set;
    logic [NREG-1:0]  w_busy_eff;

    logic             r_wen;
    logic [AW-1:0]    r_waddr;
    logic [XLEN-1:0]  r_wdata;

    logic             w_accept;
    logic             w_op_fire;
    logic             w_haz_in;
    logic             w_haz_cap;

    // Register 0 never needs a producer; a source reads as hazardous only if
    // it is used, non-zero and marked busy.
    function automatic logic f_hazard(
        input logic            u1,
        input logic [AW-1:0]   a1,
        input logic            u2,
        input logic [AW-1:0]   a2,
        input logic [NREG-1:0] busy
    );
        return (u1 && (a1 != '0) && busy[a1]) ||
               (u2 && (a2 != '0) && busy[a2]);
    endfunction

    assign w_accept  = (r_state == S_IDLE) && id_valid;
    assign w_op_fire = (r_state == S_VALID) && op_ready;

    always_comb begin
        w_wb_clr = '0;
        if (wb_valid) begin
            w_wb_clr[wb_rd] = 1'b1;
        end
    end

    always_comb begin
        w_op_set = '0;
        if (w_op_fire && r_rd_wen && (r_rd != '0)) begin
            w_op_set[r_rd] = 1'b1;
        end
    end

    // A writeback landing this cycle already releases its register, so the
    // stall check looks at the scoreboard with that bit removed.
    assign w_busy_eff = r_busy & ~w_wb_clr;

    always_comb begin
        // set after clear: an op issuing to the same rd as a retiring
        // writeback leaves the register busy for the new producer
        w_busy_nxt    = (r_busy & ~w_wb_clr) | w_op_set;
        w_busy_nxt[0] = 1'b0;
    end

    assign w_haz_in  = f_hazard(id_use_rs1, id_rs1, id_use_rs2, id_rs2, w_busy_eff);
    assign w_haz_cap = f_hazard(r_use1, r_rs1, r_use2, r_rs2, w_busy_eff);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (id_valid) w_state_nxt = w_haz_in ? S_STALL : S_ISSUE;
            S_STALL:   if (!w_haz_cap) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_VALID;
            S_VALID:   if (op_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_use1   <= 1'b0;
            r_use2   <= 1'b0;
            r_rd     <= '0;
            r_rd_wen <= 1'b0;
        end else if (w_accept) begin
            r_rs1    <= id_rs1;
            r_rs2    <= id_rs2;
            r_use1   <= id_use_rs1;
            r_use2   <= id_use_rs2;
            r_rd     <= id_rd;
            r_rd_wen <= id_rd_wen;
        end
    end

    // Read addresses are loaded only on entry to ISSUE and hold otherwise,
    // so the regfile address lines stay quiet while stalled.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_raddr_1 <= '0;
            r_raddr_2 <= '0;
        end else if (w_state_nxt == S_ISSUE) begin
            r_raddr_1 <= (r_state == S_IDLE) ? id_rs1 : r_rs1;
            r_raddr_2 <= (r_state == S_IDLE) ? id_rs2 : r_rs2;
        end
    end

    // The regfile returns data one cycle after ren, i.e. during CAPTURE.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_op1 <= '0;
            r_op2 <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_op1 <= r_use1 ? reg_rdata_1 : '0;
            r_op2 <= r_use2 ? reg_rdata_2 : '0;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Writebacks bypass the FSM entirely: one registered write per wb beat.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= wb_valid && (wb_rd != '0);
            if (wb_valid) begin
                r_waddr <= wb_rd;
                r_wdata <= wb_data;
            end
        end
    end

    assign id_ready    = (r_state == S_IDLE);
    assign op_valid    = (r_state == S_VALID);
    assign op_rs1_data = r_op1;
    assign op_rs2_data = r_op2;
    assign op_rd       = r_rd;
    assign op_rd_wen   = r_rd_wen;
    assign wb_ready    = 1'b1;
    assign reg_raddr_1 = r_raddr_1;
    assign reg_raddr_2 = r_raddr_2;
    assign reg_ren_1   = (r_state == S_ISSUE) && r_use1;
    assign reg_ren_2   = (r_state == S_ISSUE) && r_use2;
    assign reg_waddr   = r_waddr;
    assign reg_wen     = r_wen;
    assign reg_wdata   = r_wdata;
    assign busy_mask   = r_busy;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_regfile_req_ctrl.sv
module tb_regfile_req_ctrl;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_STALL   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_VALID   = 3'd4;

    logic             hclk;
    logic             hrstn;
    logic             id_valid;
    logic             id_ready;
    logic [AW-1:0]    id_rs1;
    logic [AW-1:0]    id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [AW-1:0]    id_rd;
    logic             id_rd_wen;
    logic             op_valid;
    logic             op_ready;
    logic [XLEN-1:0]  op_rs1_data;
    logic [XLEN-1:0]  op_rs2_data;
    logic [AW-1:0]    op_rd;
    logic             op_rd_wen;
    logic             wb_valid;
    logic             wb_ready;
    logic [AW-1:0]    wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic [AW-1:0]    reg_raddr_1;
    logic [AW-1:0]    reg_raddr_2;
    logic             reg_ren_1;
    logic             reg_ren_2;
    logic [XLEN-1:0]  reg_rdata_1;
    logic [XLEN-1:0]  reg_rdata_2;
    logic [AW-1:0]    reg_waddr;
    logic             reg_wen;
    logic [XLEN-1:0]  reg_wdata;
    logic [31:0]      busy_mask;
    logic [2:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    regfile_req_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
        .hclk(hclk), .hrstn(hrstn),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
        .op_rd(op_rd), .op_rd_wen(op_rd_wen),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .reg_raddr_1(reg_raddr_1), .reg_raddr_2(reg_raddr_2),
        .reg_ren_1(reg_ren_1), .reg_ren_2(reg_ren_2),
        .reg_rdata_1(reg_rdata_1), .reg_rdata_2(reg_rdata_2),
        .reg_waddr(reg_waddr), .reg_wen(reg_wen), .reg_wdata(reg_wdata),
        .busy_mask(busy_mask), .dbg_state(dbg_state)
    );

    // clock / reset
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // regfile peer: registered read, 0 when ren low, write-to-read bypass
    logic [XLEN-1:0] rf_mem [32];

    always @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            reg_rdata_1 <= '0;
            reg_rdata_2 <= '0;
        end else begin
            reg_rdata_1 <= !reg_ren_1 ? '0 :
                           (reg_wen && reg_waddr == reg_raddr_1) ? reg_wdata : rf_mem[reg_raddr_1];
            reg_rdata_2 <= !reg_ren_2 ? '0 :
                           (reg_wen && reg_waddr == reg_raddr_2) ? reg_wdata : rf_mem[reg_raddr_2];
            if (reg_wen && reg_waddr != '0) rf_mem[reg_waddr] <= reg_wdata;
        end
    end

    // checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic send_req(input logic [AW-1:0] rs1, input logic u1,
                            input logic [AW-1:0] rs2, input logic u2,
                            input logic [AW-1:0] rd,  input logic wen);
        id_rs1 = rs1; id_use_rs1 = u1;
        id_rs2 = rs2; id_use_rs2 = u2;
        id_rd  = rd;  id_rd_wen  = wen;
        id_valid = 1'b1;
        step();
        id_valid = 1'b0;
    endtask

    // from ISSUE: two edges reach VALID, then one edge with op_ready fires
    task automatic issue_to_fire();
        step();
        step();
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        rf_mem[3] = 32'h11;
        rf_mem[4] = 32'h22;
        hrstn = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_rd_wen = 0; op_ready = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;

        // reset state
        step();
        chk("rst_state", dbg_state, S_IDLE);
        chk("rst_id_ready", id_ready, 1);
        chk("rst_wb_ready", wb_ready, 1);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_reg_wen", reg_wen, 0);
        chk("rst_ren", {reg_ren_1, reg_ren_2}, 0);
        chk("rst_data", op_rs1_data | op_rs2_data, 0);
        step();
        hrstn = 1'b1;
        step();

        // no hazard: rs1=3, rs2=4
        send_req(5'd3, 1, 5'd4, 1, 5'd0, 0);
        chk("nh_state_issue", dbg_state, S_ISSUE);
        chk("nh_ren", {reg_ren_1, reg_ren_2}, 2'b11);
        chk("nh_raddr_1", reg_raddr_1, 3);
        chk("nh_raddr_2", reg_raddr_2, 4);
        chk("nh_id_ready", id_ready, 0);
        step();
        chk("nh_capture_ren", {reg_ren_1, reg_ren_2}, 0);
        chk("nh_capture_opv", op_valid, 0);
        chk("nh_raddr_hold", reg_raddr_1, 3);
        step();
        chk("nh_op_valid", op_valid, 1);
        chk("nh_rs1_data", op_rs1_data, 32'h11);
        chk("nh_rs2_data", op_rs2_data, 32'h22);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        chk("nh_idle", dbg_state, S_IDLE);
        chk("nh_opv_low", op_valid, 0);

        // RAW stall on rd=5
        send_req(5'd1, 1, 5'd0, 0, 5'd5, 1);
        issue_to_fire();
        chk("raw_busy5", busy_mask, 32'h20);
        send_req(5'd5, 1, 5'd0, 0, 5'd0, 0);
        chk("raw_stall", dbg_state, S_STALL);
        chk("raw_stall_ren", reg_ren_1, 0);
        step();
        chk("raw_stall_hold", dbg_state, S_STALL);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hABCD;
        step();
        wb_valid = 1'b0;
        chk("raw_issue", dbg_state, S_ISSUE);
        chk("raw_busy_clr", busy_mask, 0);
        chk("raw_reg_wen", reg_wen, 1);
        chk("raw_waddr", reg_waddr, 5);
        chk("raw_wdata", reg_wdata, 32'hABCD);
        chk("raw_raddr", reg_raddr_1, 5);
        step();
        chk("raw_wen_pulse", reg_wen, 0);
        step();
        chk("raw_op_valid", op_valid, 1);
        chk("raw_rs1_data", op_rs1_data, 32'hABCD);
        chk("raw_rs2_data", op_rs2_data, 0);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;

        // backpressure
        send_req(5'd3, 1, 5'd4, 1, 5'd6, 0);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_op_valid", op_valid, 1);
            chk("bp_rs1", op_rs1_data, 32'h11);
            chk("bp_rs2", op_rs2_data, 32'h22);
            chk("bp_rd", op_rd, 6);
            chk("bp_id_ready", id_ready, 0);
            step();
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        chk("bp_release_idle", dbg_state, S_IDLE);
        chk("bp_release_opv", op_valid, 0);

        // rd0 / unused source
        send_req(5'd0, 1, 5'd4, 0, 5'd0, 0);
        chk("z_no_stall", dbg_state, S_ISSUE);
        chk("z_ren", {reg_ren_1, reg_ren_2}, 2'b10);
        step();
        step();
        chk("z_opv", op_valid, 1);
        chk("z_data", {op_rs1_data, op_rs2_data} != 0, 0);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
        step();
        wb_valid = 1'b0;
        chk("z_wb_rd0", reg_wen, 0);

        // set/clear collision on rd=7, then back-to-back writebacks
        send_req(5'd0, 0, 5'd0, 0, 5'd7, 1);
        step();
        step();
        op_ready = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        step();
        op_ready = 1'b0;
        chk("col_busy7", busy_mask, 32'h80);
        chk("col_wen", reg_wen, 1);
        wb_rd = 5'd7; wb_data = 32'h78;
        step();
        chk("col_clear", busy_mask, 0);
        wb_rd = 5'd2; wb_data = 32'h202;
        step();
        chk("b2b_wen_a", reg_wen, 1);
        chk("b2b_addr_a", reg_waddr, 2);
        wb_rd = 5'd3; wb_data = 32'h303;
        step();
        wb_valid = 1'b0;
        chk("b2b_wen_b", reg_wen, 1);
        chk("b2b_addr_b", reg_waddr, 3);
        chk("b2b_data_b", reg_wdata, 32'h303);
        step();
        chk("b2b_wen_end", reg_wen, 0);

        // reset while stalled with a writeback presented
        send_req(5'd0, 0, 5'd0, 0, 5'd9, 1);
        issue_to_fire();
        send_req(5'd9, 1, 5'd0, 0, 5'd0, 0);
        chk("rs_stall", dbg_state, S_STALL);
        chk("rs_busy9", busy_mask, 32'h200);
        wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hDEAD;
        hrstn = 1'b0;
        #1;
        chk("rs_state", dbg_state, S_IDLE);
        chk("rs_busy", busy_mask, 0);
        chk("rs_id_ready", id_ready, 1);
        chk("rs_op_valid", op_valid, 0);
        step();
        chk("rs_reg_wen", reg_wen, 0);
        chk("rs_waddr", reg_waddr, 0);
        wb_valid = 1'b0;
        hrstn = 1'b1;
        step();
        chk("rs_after_wen", reg_wen, 0);
        chk("rs_after_state", dbg_state, S_IDLE);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
